fp_matmul: RTL and testbench

FP_MATMUL -- requirements
Module: fp_matmul

---
 rtl/ibex_pkg.sv | 10 +
 rtl/Add_Sub.sv | 67 ++++++
 rtl/Mult.sv | 41 ++++
 rtl/fp_mac_unit.sv | 36 +++
 rtl/fp_matmul.sv | 167 ++++++++++++++++
 tb/tb_fp_matmul.sv | 294 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the bfloat16 matrix multiplier: FSM states, operand select, adder op.
package ibex_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fp_mm_state_e;
  typedef enum logic {MM_SEL_A, MM_SEL_B} fp_mm_sel_e;
  typedef enum logic {FP_ALU_ADD, FP_ALU_SUB} fp_alu_op_e;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;

endpackage

// File: rtl/Add_Sub.sv
// bfloat16 adder/subtractor with guard/round/sticky rounding to nearest even, subnormals flushed.
module Add_Sub
  import ibex_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        op_i,
  output logic [15:0] y_o
);

  logic              sb, sx, sy, swap, eff_sub, sticky, inc;
  logic [7:0]        ex, ey, d;
  logic [6:0]        fx, fy;
  logic [10:0]       mx, my, sh;
  logic [11:0]       sum;
  logic [9:0]        norm;
  logic [3:0]        lz;
  logic signed [9:0] exp_s;
  logic [14:0]       packed_r;

  always_comb begin
    sb   = b_i[15] ^ (op_i == FP_ALU_SUB);
    swap = b_i[14:0] > a_i[14:0];
    sx   = swap ? sb : a_i[15];
    sy   = swap ? a_i[15] : sb;
    ex   = swap ? b_i[14:7] : a_i[14:7];
    ey   = swap ? a_i[14:7] : b_i[14:7];
    fx   = swap ? b_i[6:0] : a_i[6:0];
    fy   = swap ? a_i[6:0] : b_i[6:0];
    d    = ex - ey;
    mx   = {1'b1, fx, 3'b000};
    sh   = {1'b1, fy, 3'b000};
    if (d >= 8'd11) begin
      my     = '0;
      sticky = 1'b1;
    end else begin
      my     = sh >> d;
      sticky = |(sh & ~(11'h7FF << d));
    end
    my[0]   = my[0] | sticky;
    eff_sub = sx ^ sy;
    sum     = eff_sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
    lz      = 4'd0;
    for (int j = 0; j < 11; j++) begin
      if (sum[j]) lz = 4'(10 - j);
    end
    exp_s = $signed({2'b00, ex});
    if (sum[11]) begin
      norm  = {sum[10:2], |sum[1:0]};
      exp_s = exp_s + 10'sd1;
    end else begin
      norm  = sum[9:0] << lz;
      exp_s = exp_s - $signed({6'd0, lz});
    end
    inc      = norm[2] & ((|norm[1:0]) | norm[3]);
    packed_r = {exp_s[7:0], norm[9:3]} + {14'd0, inc};
    y_o      = {sx, packed_r};
    if (a_i[14:7] == 8'hFF || b_i[14:7] == 8'hFF) y_o = BF16_QNAN;
    else if (a_i[14:7] == 8'h00 && b_i[14:7] == 8'h00) y_o = {a_i[15] & sb, 15'd0};
    else if (a_i[14:7] == 8'h00) y_o = {sb, b_i[14:0]};
    else if (b_i[14:7] == 8'h00) y_o = a_i;
    else if (sum == 12'd0) y_o = 16'h0000;
    else if (exp_s >= 10'sd255) y_o = {sx, 8'hFF, 7'd0};
    else if (exp_s <= 10'sd0) y_o = {sx, 15'd0};
  end

endmodule

// File: rtl/Mult.sv
// bfloat16 multiplier: round-to-nearest-even, subnormals flushed to zero, overflow to infinity.
module Mult
  import ibex_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o
);

  logic              sign;
  logic [15:0]       prod;
  logic signed [9:0] exp_s;
  logic [6:0]        man;
  logic              guard, sticky, inc;
  logic [14:0]       packed_r;

  always_comb begin
    sign  = a_i[15] ^ b_i[15];
    prod  = {8'd0, 1'b1, a_i[6:0]} * {8'd0, 1'b1, b_i[6:0]};
    exp_s = $signed({2'b00, a_i[14:7]}) + $signed({2'b00, b_i[14:7]}) - 10'sd127;
    if (prod[15]) begin
      exp_s  = exp_s + 10'sd1;
      man    = prod[14:8];
      guard  = prod[7];
      sticky = |prod[6:0];
    end else begin
      man    = prod[13:7];
      guard  = prod[6];
      sticky = |prod[5:0];
    end
    inc      = guard & (sticky | man[0]);
    // a mantissa carry out of rounding ripples into the exponent field
    packed_r = {exp_s[7:0], man} + {14'd0, inc};
    y_o      = {sign, packed_r};
    if (a_i[14:7] == 8'hFF || b_i[14:7] == 8'hFF) y_o = BF16_QNAN;
    else if (a_i[14:7] == 8'h00 || b_i[14:7] == 8'h00) y_o = {sign, 15'd0};
    else if (exp_s >= 10'sd255) y_o = {sign, 8'hFF, 7'd0};
    else if (exp_s <= 10'sd0) y_o = {sign, 15'd0};
  end

endmodule

// File: rtl/fp_mac_unit.sv
// Multiply-add datapath acc + a*b; FP_MATMUL_PIPE_EN inserts a product register before the adder.
module fp_mac_unit
  import ibex_pkg::*;
(
`ifdef FP_MATMUL_PIPE_EN
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
`endif
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [15:0] acc_i,
  output logic [15:0] sum_o
);

  logic [15:0] prod;
  logic [15:0] addend;

  Mult u_mult (.a_i(a_i), .b_i(b_i), .y_o(prod));

`ifdef FP_MATMUL_PIPE_EN
  logic [15:0] prod_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prod_reg <= '0;
    else if (en_i) prod_reg <= prod;
  end

  assign addend = prod_reg;
`else
  assign addend = prod;
`endif

  Add_Sub u_add (.a_i(acc_i), .b_i(addend), .op_i(FP_ALU_ADD), .y_o(sum_o));

endmodule

// File: rtl/fp_matmul.sv
// DIM x DIM bfloat16 matrix multiply C = A*B or C += A*B, one MAC per cycle.
// Define FP_MATMUL_PIPE_EN to register the product (RUN gains one drain cycle).
module fp_matmul
  import ibex_pkg::*;
#(
  parameter int   DIM   = 8,
  localparam int  IDX_W = $clog2(DIM)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             accum_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             wr_en_i,
  input  logic             wr_sel_i,
  input  logic [IDX_W-1:0] wr_row_i,
  input  logic [IDX_W-1:0] wr_col_i,
  input  logic [15:0]      wr_data_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_row_i,
  input  logic [IDX_W-1:0] rd_col_i,
  output logic [15:0]      rd_data_o,
  output logic             rd_valid_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

  fp_mm_state_e     state_reg;
  logic             busy_reg, done_reg, accum_reg, rd_valid_reg;
  logic [15:0]      rd_data_reg, acc_reg, acc_in, mac_sum;
  logic [IDX_W-1:0] i_reg, k_reg, x_reg;
  logic [IDX_W-1:0] ai, ak, ax;
  logic             issue, last_issue, run_end, add_vld, wr_ok;
  logic [15:0]      a_mem [DIM][DIM];
  logic [15:0]      b_mem [DIM][DIM];
  logic [15:0]      c_mem [DIM][DIM];

  assign last_issue = (i_reg == LAST) && (k_reg == LAST) && (x_reg == LAST);
  assign wr_ok      = wr_en_i && !busy_reg;

`ifdef FP_MATMUL_PIPE_EN
  // Add stage trails the multiply stage by one cycle, so its indices are delayed copies.
  logic             drain_reg, add_vld_reg;
  logic [IDX_W-1:0] ai_reg, ak_reg, ax_reg;

  assign issue   = (state_reg == RUN) && !drain_reg;
  assign run_end = drain_reg;
  assign add_vld = add_vld_reg;
  assign ai      = ai_reg;
  assign ak      = ak_reg;
  assign ax      = ax_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drain_reg   <= 1'b0;
      add_vld_reg <= 1'b0;
      ai_reg      <= '0;
      ak_reg      <= '0;
      ax_reg      <= '0;
    end else begin
      drain_reg   <= issue && last_issue;
      add_vld_reg <= issue;
      ai_reg      <= i_reg;
      ak_reg      <= k_reg;
      ax_reg      <= x_reg;
    end
  end
`else
  assign issue   = (state_reg == RUN);
  assign run_end = last_issue;
  assign add_vld = issue;
  assign ai      = i_reg;
  assign ak      = k_reg;
  assign ax      = x_reg;
`endif

  assign acc_in = (ax != '0) ? acc_reg : (accum_reg ? c_mem[ai][ak] : 16'h0000);

  fp_mac_unit u_mac (
`ifdef FP_MATMUL_PIPE_EN
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (issue),
`endif
    .a_i    (a_mem[i_reg][x_reg]),
    .b_i    (b_mem[x_reg][k_reg]),
    .acc_i  (acc_in),
    .sum_o  (mac_sum)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      accum_reg <= 1'b0;
      i_reg     <= '0;
      k_reg     <= '0;
      x_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (start_i) begin
          state_reg <= RUN;
          busy_reg  <= 1'b1;
          accum_reg <= accum_i;
          i_reg     <= '0;
          k_reg     <= '0;
          x_reg     <= '0;
        end
        RUN: begin
          if (issue) begin
            x_reg <= (x_reg == LAST) ? '0 : x_reg + 1'b1;
            if (x_reg == LAST) k_reg <= (k_reg == LAST) ? '0 : k_reg + 1'b1;
            if (x_reg == LAST && k_reg == LAST) i_reg <= (i_reg == LAST) ? '0 : i_reg + 1'b1;
          end
          if (run_end) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_reg <= '0;
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
          c_mem[r][c] <= '0;
        end
      end
    end else begin
      if (wr_ok) begin
        if (fp_mm_sel_e'(wr_sel_i) == MM_SEL_B) b_mem[wr_row_i][wr_col_i] <= wr_data_i;
        else a_mem[wr_row_i][wr_col_i] <= wr_data_i;
      end
      if (add_vld) acc_reg <= mac_sum;
      if (add_vld && ax == LAST) c_mem[ai][ak] <= mac_sum;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= rd_en_i && !busy_reg;
      if (rd_en_i && !busy_reg) rd_data_reg <= c_mem[rd_row_i][rd_col_i];
    end
  end

  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign rd_valid_o = rd_valid_reg;
  assign rd_data_o  = rd_data_reg;

endmodule

// File: tb/tb_fp_matmul.sv
// Scoreboard bench for fp_matmul: reads push expectations, a monitor pops them on rd_valid_o.
module tb_fp_matmul;

  localparam int DIM   = 8;
  localparam int IDX_W = $clog2(DIM);
`ifdef FP_MATMUL_PIPE_EN
  localparam int RUN_CYC = DIM * DIM * DIM + 1;
`else
  localparam int RUN_CYC = DIM * DIM * DIM;
`endif

  logic             clk_i = 1'b0, rst_ni = 1'b0;
  logic             start_i = 1'b0, accum_i = 1'b0;
  logic             wr_en_i = 1'b0, wr_sel_i = 1'b0, rd_en_i = 1'b0;
  logic [IDX_W-1:0] wr_row_i = '0, wr_col_i = '0, rd_row_i = '0, rd_col_i = '0;
  logic [15:0]      wr_data_i = '0;
  logic             busy_o, done_o, rd_valid_o;
  logic [15:0]      rd_data_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          r;
    int          c;
    logic [15:0] v;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  logic [15:0] a_m [DIM][DIM];
  logic [15:0] b_m [DIM][DIM];
  logic [15:0] c_m [DIM][DIM];

  always #5 clk_i = ~clk_i;

  fp_matmul #(.DIM(DIM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .accum_i(accum_i),
    .busy_o(busy_o), .done_o(done_o),
    .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i), .wr_row_i(wr_row_i), .wr_col_i(wr_col_i),
    .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_row_i(rd_row_i), .rd_col_i(rd_col_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Real-valued reference: exact products/sums in double, then one RNE rounding to bfloat16.
  function automatic real bf2r(input logic [15:0] v);
    real m = 1.0 + real'(int'(v[6:0])) / 128.0;
    int  e = int'(v[14:7]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    real  a, sc, fr;
    int   e, mi;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    sc = a * 128.0;
    mi = int'($floor(sc));
    fr = sc - real'(mi);
    if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
    if (mi == 256) begin mi = 128; e++; end
    if (e >= 255) return {s, 8'hFF, 7'h00};
    if (e <= 0) return {s, 15'h0000};
    return {s, 8'(e), 7'(mi)};
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    if (a[14:7] == 8'h00 || b[14:7] == 8'h00) return {a[15] ^ b[15], 15'h0000};
    return r2bf(bf2r(a) * bf2r(b));
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    real s;
    if (a[14:7] == 8'h00 && b[14:7] == 8'h00) return {a[15] & b[15], 15'h0000};
    if (a[14:7] == 8'h00) return b;
    if (b[14:7] == 8'h00) return a;
    s = bf2r(a) + bf2r(b);
    if (s == 0.0) return 16'h0000;
    return r2bf(s);
  endfunction

  task automatic model_run(input logic acc);
    logic [15:0] s;
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        s = acc ? c_m[i][k] : 16'h0000;
        for (int x = 0; x < DIM; x++) s = m_add(s, m_mul(a_m[i][x], b_m[x][k]));
        c_m[i][k] = s;
      end
    end
  endtask

  task automatic fill_c(input logic [15:0] v);
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) c_m[r][c] = v;
  endtask

  task automatic load_mats();
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          @(negedge clk_i);
          wr_en_i   = 1'b1;
          wr_sel_i  = s[0];
          wr_row_i  = IDX_W'(r);
          wr_col_i  = IDX_W'(c);
          wr_data_i = (s == 1) ? b_m[r][c] : a_m[r][c];
        end
      end
    end
    @(negedge clk_i);
    wr_en_i = 1'b0;
  endtask

  task automatic read_one(input int r, input int c, input logic [15:0] v);
    rd_exp_t e;
    @(negedge clk_i);
    rd_en_i  = 1'b1;
    rd_row_i = IDX_W'(r);
    rd_col_i = IDX_W'(c);
    e.r = r; e.c = c; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic read_all();
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) read_one(r, c, c_m[r][c]);
    @(negedge clk_i);
    rd_en_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  // One computation; optional co-issued write, mid-run start+write, mid-run read, mid-run reset.
  task automatic run(input logic acc, input bit co_wr, input int inj_cyc, input int rd_cyc,
                     input int rst_cyc, input string tag);
    int cyc, pulses, done_cyc;
    @(negedge clk_i);
    start_i = 1'b1;
    accum_i = acc;
    if (co_wr) begin
      wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_row_i = '0; wr_col_i = '0; wr_data_i = 16'h4000;
    end
    @(negedge clk_i);
    start_i = 1'b0;
    accum_i = 1'b0;
    wr_en_i = 1'b0;
    check({tag, " busy at entry"}, 32'(busy_o), 32'd1);
    cyc = 0; pulses = 0; done_cyc = -1;
    while (cyc < RUN_CYC + 5) begin
      @(negedge clk_i);
      cyc++;
      start_i = 1'b0;
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      if (done_o) begin
        pulses++;
        if (pulses == 1) done_cyc = cyc;
        check({tag, " busy with done"}, 32'(busy_o), 32'd1);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) check({tag, " busy after done"}, 32'(busy_o), 32'd0);
      if (cyc == rd_cyc + 1) check({tag, " rd_valid during run"}, 32'(rd_valid_o), 32'd0);
      if (cyc == rd_cyc) begin
        rd_en_i = 1'b1; rd_row_i = '0; rd_col_i = '0;
      end
      if (cyc == inj_cyc) begin
        start_i = 1'b1; accum_i = 1'b1;
        wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_row_i = '0; wr_col_i = '0; wr_data_i = 16'h4000;
      end
      if (cyc == rst_cyc) begin
        rst_ni = 1'b0;
        #1;
        check({tag, " busy right after reset"}, 32'(busy_o), 32'd0);
        check({tag, " done right after reset"}, 32'(done_o), 32'd0);
      end
    end
    accum_i = 1'b0;
    if (rst_cyc < 0) begin
      check({tag, " cycles to done"}, 32'(done_cyc), 32'(RUN_CYC));
      check({tag, " done pulses"}, 32'(pulses), 32'd1);
    end else begin
      check({tag, " done pulses after abort"}, 32'(pulses), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
    end
    $display("run %s: done at cycle %0d, %0d pulse(s)", tag, done_cyc, pulses);
  endtask

  initial begin : monitor
    rd_exp_t e;
    forever begin
      @(negedge clk_i);
      if (rd_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected rd_valid: got data %h with no read pending", rd_data_o);
        end else begin
          e = exp_q.pop_front();
          if (rd_data_o !== e.v) begin
            errors++;
            $display("FAIL rd C[%0d][%0d]: got %h expected %h", e.r, e.c, rd_data_o, e.v);
          end else begin
            $display("rd C[%0d][%0d] = %h", e.r, e.c, rd_data_o);
          end
        end
      end
    end
  end

  initial begin : stim
    repeat (3) @(negedge clk_i);
    check("reset busy_o", 32'(busy_o), 32'd0);
    check("reset done_o", 32'(done_o), 32'd0);
    check("reset rd_valid_o", 32'(rd_valid_o), 32'd0);
    check("reset rd_data_o", 32'(rd_data_o), 32'd0);
    rst_ni = 1'b1;
    fill_c(16'h0000);
    read_one(0, 0, 16'h0000);
    @(negedge clk_i);
    rd_en_i = 1'b0;
    check("idle read latency", 32'(rd_valid_o), 32'd1);
    repeat (2) @(negedge clk_i);

    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) begin
      a_m[r][c] = 16'h3F80;
      b_m[r][c] = 16'h4000;
    end
    load_mats();
    run(1'b0, 1'b0, -1, 50, -1, "ones x twos");
    fill_c(16'h4180);
    read_all();

    run(1'b1, 1'b0, -1, -1, -1, "accumulate");
    fill_c(16'h4200);
    read_all();

    run(1'b0, 1'b0, 100, -1, -1, "inject start+wr");
    fill_c(16'h4180);
    read_all();

    // Co-issued write lands first: A[0][0]=2 makes row 0 sum 2*2 + 7*2 = 18.
    run(1'b0, 1'b1, -1, -1, -1, "start with write");
    a_m[0][0] = 16'h4000;
    fill_c(16'h4180);
    for (int c = 0; c < DIM; c++) c_m[0][c] = 16'h4190;
    read_all();

    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) begin
      a_m[r][c] = (r == c) ? 16'h3F80 : 16'h0000;
      b_m[r][c] = {1'($urandom_range(1)), 8'($urandom_range(134, 120)), 7'($urandom_range(127))};
    end
    load_mats();
    run(1'b0, 1'b0, -1, -1, -1, "identity");
    model_run(1'b0);
    read_all();

    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++)
      a_m[r][c] = {1'($urandom_range(1)), 8'($urandom_range(130, 124)), 7'($urandom_range(127))};
    load_mats();
    run(1'b1, 1'b0, -1, -1, -1, "random accumulate");
    model_run(1'b1);
    read_all();

    run(1'b0, 1'b0, -1, -1, 200, "reset abort");
    fill_c(16'h0000);
    read_one(3, 5, 16'h0000);
    read_one(0, 0, 16'h0000);
    @(negedge clk_i);
    rd_en_i = 1'b0;
    repeat (3) @(negedge clk_i);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending reads: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
